// File: rtl/seg_scan_mux_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
package seg_scan_mux_pkg;

    // Scan slot phases: all digits off, then one digit driven.
    typedef enum logic {
        ST_DEAD = 1'b0,
        ST_ON   = 1'b1
    } scan_state_e;

    // Brightness resolution: an ON slot is split into this many PWM steps.
    localparam int BRIGHT_STEPS = 16;

    // Segment patterns, bit order {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] SEG_BLANK = 7'b000_0000;
    localparam logic [6:0] SEG_0     = 7'b111_1110;
    localparam logic [6:0] SEG_1     = 7'b011_0000;
    localparam logic [6:0] SEG_2     = 7'b110_1101;
    localparam logic [6:0] SEG_3     = 7'b111_1001;
    localparam logic [6:0] SEG_4     = 7'b011_0011;
    localparam logic [6:0] SEG_5     = 7'b101_1011;
    localparam logic [6:0] SEG_6     = 7'b101_1111;
    localparam logic [6:0] SEG_7     = 7'b111_0000;
    localparam logic [6:0] SEG_8     = 7'b111_1111;
    localparam logic [6:0] SEG_9     = 7'b111_1011;

    // Decimal glyph lookup for upstream formatting logic; non-digits are blank.
    function automatic logic [6:0] seg_glyph(input logic [3:0] val);
        logic [6:0] g;
        case (val)
            4'd0:    g = SEG_0;
            4'd1:    g = SEG_1;
            4'd2:    g = SEG_2;
            4'd3:    g = SEG_3;
            4'd4:    g = SEG_4;
            4'd5:    g = SEG_5;
            4'd6:    g = SEG_6;
            4'd7:    g = SEG_7;
            4'd8:    g = SEG_8;
            4'd9:    g = SEG_9;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // Slot counter width: must hold the longer of the DEAD and ON phases.
    function automatic int cnt_width(input int slot_cycles, input int dead_cycles);
        int m;
        m = (slot_cycles > dead_cycles) ? slot_cycles : dead_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_mux_slot_timer.sv
// DEAD/ON slot sequencer with strobes on the last cycle of each phase.
// Latency: strobes are combinational from the registered state/count.
// Backpressure: none; free-running while rst is low.
module scan_slot_timer
    import seg_scan_mux_pkg::*;
#(
    parameter int SLOT_CYCLES = 5000,
    parameter int DEAD_CYCLES = 16,
    parameter int CNT_W       = cnt_width(SLOT_CYCLES, DEAD_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    output scan_state_e      o_state,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_slot_start,
    output logic             o_slot_end
);

    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // slot_start marks the last DEAD cycle (next cycle is ON); slot_end the last ON cycle.
    assign o_slot_start = (state_q == ST_DEAD) && (cnt_q == DEAD_LAST);
    assign o_slot_end   = (state_q == ST_ON)   && (cnt_q == SLOT_LAST);
    assign o_state      = state_q;
    assign o_cnt        = cnt_q;

    // Next state: count within the phase, reload 0 on every phase change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        if (o_slot_start) begin
            state_d = ST_ON;
            cnt_d   = '0;
        end else if (o_slot_end) begin
            state_d = ST_DEAD;
            cnt_d   = '0;
        end
    end

    // Phase and count registers; rst parks the timer at the start of a DEAD phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_DEAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed N-digit 7-segment driver with dead time, PWM brightness, blink/blank.
// Latency: all pins registered, one cycle behind the scan FSM.
// Backpressure: none; inputs are sampled per digit at the start of its ON slot.
module seg_scan_mux
    import seg_scan_mux_pkg::*;
#(
    parameter int N_DIGITS     = 6,
    parameter int SLOT_CYCLES  = 5000,
    parameter int DEAD_CYCLES  = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic [7*N_DIGITS-1:0] i_digit_seg,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic [N_DIGITS-1:0]   i_blink,
    input  logic [N_DIGITS-1:0]   i_blank,
    input  logic [3:0]            i_bright,
    output logic [N_DIGITS-1:0]   o_seg_enb,
    output logic [6:0]            o_seg,
    output logic                  o_seg_dp,
    output logic                  o_frame
);

    localparam int CNT_W   = cnt_width(SLOT_CYCLES, DEAD_CYCLES);
    localparam int ON_W    = CNT_W + 1;
    localparam int ON_STEP = SLOT_CYCLES / BRIGHT_STEPS;
    localparam int DIG_W   = $clog2(N_DIGITS);
    localparam int FRM_W   = $clog2(BLINK_FRAMES + 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(N_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    // Disable behaves as a reset for the scan, but not for blink timing.
    logic clr;
    assign clr = rst | ~i_en;

    scan_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic             slot_start;
    logic             slot_end;

    scan_slot_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .DEAD_CYCLES (DEAD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk          (clk),
        .rst          (clr),
        .o_state      (state),
        .o_cnt        (cnt),
        .o_slot_start (slot_start),
        .o_slot_end   (slot_end)
    );

    logic [DIG_W-1:0]    digit_q, digit_d;
    logic [FRM_W-1:0]    frame_q, frame_d;
    logic                phase_q, phase_d;
    logic                wrap_q, wrap_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic                blink_q, blink_d;
    logic                blank_q, blank_d;
    logic [3:0]          bright_q, bright_d;
    logic [N_DIGITS-1:0] enb_out_q, enb_out_d;
    logic [6:0]          seg_out_q, seg_out_d;
    logic                dp_out_q, dp_out_d;
    logic                frame_out_q, frame_out_d;
    logic [ON_W-1:0]     on_len;
    logic                lit;

    // Digit index advances at each slot end; a wrap bumps the frame count and blink phase.
    always_comb begin
        digit_d = digit_q;
        frame_d = frame_q;
        phase_d = phase_q;
        wrap_d  = 1'b0;
        if (slot_end) begin
            if (digit_q == DIG_LAST) begin
                digit_d = '0;
                wrap_d  = 1'b1;
                if (frame_q == FRM_LAST) begin
                    frame_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    frame_d = frame_q + FRM_W'(1);
                end
            end else begin
                digit_d = digit_q + DIG_W'(1);
            end
        end
    end

    // Snapshot the current digit's inputs as its ON slot begins, so mid-slot edits wait.
    always_comb begin
        seg_d    = seg_q;
        dp_d     = dp_q;
        blink_d  = blink_q;
        blank_d  = blank_q;
        bright_d = bright_q;
        if (slot_start) begin
            seg_d    = i_digit_seg[7*int'(digit_q) +: 7];
            dp_d     = i_dp[digit_q];
            blink_d  = i_blink[digit_q];
            blank_d  = i_blank[digit_q];
            bright_d = i_bright;
        end
    end

    // PWM compare and pin values: one enable low only while lit, everything dark otherwise.
    always_comb begin
        on_len = ON_W'((32'(bright_q) + 32'd1) * ON_STEP);
        lit    = (state == ST_ON) && ({1'b0, cnt} < on_len)
                 && !blank_q && !(blink_q && phase_q);
        for (int i = 0; i < N_DIGITS; i++) begin
            enb_out_d[i] = ~(lit && (digit_q == DIG_W'(i)));
        end
        seg_out_d   = lit ? seg_q : SEG_BLANK;
        dp_out_d    = lit & dp_q;
        frame_out_d = wrap_q;
    end

    // Blink timing survives a display disable; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
            phase_q <= 1'b0;
        end else if (i_en) begin
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end

    // Scan position, latched digit data and pin registers; rst or disable go dark at once.
    always_ff @(posedge clk) begin
        if (clr) begin
            digit_q     <= '0;
            wrap_q      <= 1'b0;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b0;
            blink_q     <= 1'b0;
            blank_q     <= 1'b0;
            bright_q    <= '0;
            enb_out_q   <= '1;
            seg_out_q   <= SEG_BLANK;
            dp_out_q    <= 1'b0;
            frame_out_q <= 1'b0;
        end else begin
            digit_q     <= digit_d;
            wrap_q      <= wrap_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            blink_q     <= blink_d;
            blank_q     <= blank_d;
            bright_q    <= bright_d;
            enb_out_q   <= enb_out_d;
            seg_out_q   <= seg_out_d;
            dp_out_q    <= dp_out_d;
            frame_out_q <= frame_out_d;
        end
    end

    assign o_seg_enb = enb_out_q;
    assign o_seg     = seg_out_q;
    assign o_seg_dp  = dp_out_q;
    assign o_frame   = frame_out_q;

endmodule
